// File: rtl/debouncer_multi.sv
// Multi-channel push-button debouncer: 2-flop synchronisers, shared tick prescaler,
// per-channel stability counters, registered rise/fall pulses. Define DEBOUNCER_MULTI_HOLD_EN for hold/auto-repeat pulses.
module debouncer_multi #(
    parameter int                  CHANNELS     = 4,
    parameter int                  TICK_DIV     = 50000,
    parameter int                  STABLE_TICKS = 20,
    parameter logic [CHANNELS-1:0] POLARITY     = {CHANNELS{1'b0}},
    parameter int                  HOLD_TICKS   = 500,
    parameter int                  REPEAT_TICKS = 100
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] push_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [CHANNELS-1:0] hold_o
);

    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STAB_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

    if (CHANNELS < 1 || TICK_DIV < 1 || STABLE_TICKS < 1 || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("debouncer_multi: every size parameter must be >= 1");
    end

    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick;
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CHANNELS-1:0] raw_s;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;

    always_comb begin
        tick    = (div_q == DIV_LAST);
        div_d   = tick ? '0 : div_q + 1'b1;
        sync1_d = push_i ^ POLARITY;
        sync2_d = sync1_q;
    end

    assign raw_s  = sync2_q;
    assign rise_d = level_d & ~level_q;
    assign fall_d = ~level_d & level_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [STAB_W-1:0] stab_q, stab_d;
            logic              lvl_d;

            // Any sample agreeing with the current level restarts the count, tick or not.
            always_comb begin
                stab_d = stab_q;
                lvl_d  = level_q[gi];
                if (raw_s[gi] == level_q[gi]) begin
                    stab_d = '0;
                end else if (tick) begin
                    if (stab_q == STAB_LAST) begin
                        lvl_d  = raw_s[gi];
                        stab_d = '0;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    stab_q <= '0;
                end else begin
                    stab_q <= stab_d;
                end
            end

            assign level_d[gi] = lvl_d;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            div_q   <= div_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef DEBOUNCER_MULTI_HOLD_EN
    localparam int HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_TICKS - 1);

    logic [CHANNELS-1:0] hold_q, hold_d;

    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_hold
            logic [HOLD_W-1:0] hcnt_q, hcnt_d;
            logic              rep_q, rep_d;
            logic              pulse_d;

            // rep_q selects the repeat interval once the initial hold delay has elapsed.
            always_comb begin
                hcnt_d  = hcnt_q;
                rep_d   = rep_q;
                pulse_d = 1'b0;
                if (!level_q[gi] || rise_d[gi]) begin
                    hcnt_d = '0;
                    rep_d  = 1'b0;
                end else if (tick) begin
                    if (hcnt_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
                        hcnt_d  = '0;
                        rep_d   = 1'b1;
                        pulse_d = ~fall_d[gi];
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    hcnt_q <= '0;
                    rep_q  <= 1'b0;
                end else begin
                    hcnt_q <= hcnt_d;
                    rep_q  <= rep_d;
                end
            end

            assign hold_d[gi] = pulse_d;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold_o = hold_q;
`else
    assign hold_o = {CHANNELS{1'b0}};
`endif

endmodule
